// File: rtl/led_arbiter_if.sv
// rtl/led_arbiter_if.sv - valid/ready handshake bundle for the two LED requesters
interface led_arbiter_if;
    logic       REQ_A_VALID;
    logic [7:0] REQ_A_DATA;
    logic       REQ_A_READY;
    logic       REQ_B_VALID;
    logic [7:0] REQ_B_DATA;
    logic       REQ_B_READY;

    modport master (
        output REQ_A_VALID, REQ_A_DATA, REQ_B_VALID, REQ_B_DATA,
        input  REQ_A_READY, REQ_B_READY
    );

    modport slave (
        input  REQ_A_VALID, REQ_A_DATA, REQ_B_VALID, REQ_B_DATA,
        output REQ_A_READY, REQ_B_READY
    );
endinterface

// File: rtl/led_arbiter.sv
// rtl/led_arbiter.sv - round-robin arbiter granting two requesters timed ownership of the LEDs
module led_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] SW,
    led_arbiter_if.slave req,
    output logic [7:0] LED,
    output logic [1:0] OWNER
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_A = 2'd1,
        HOLD_B = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_b_q, last_b_d;
    logic [7:0]    led_q, led_d;
    logic [1:0]    owner_q, owner_d;
    logic          grant_a, grant_b;

    // On a tie the requester that did not win last time gets the LEDs.
    always_comb begin
        grant_a = (state_q == IDLE) && req.REQ_A_VALID && (!req.REQ_B_VALID || last_b_q);
        grant_b = (state_q == IDLE) && req.REQ_B_VALID && (!req.REQ_A_VALID || !last_b_q);
    end

    assign req.REQ_A_READY = grant_a && !RST;
    assign req.REQ_B_READY = grant_b && !RST;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;
        led_d    = led_q;
        owner_d  = owner_q;
        case (state_q)
            IDLE: begin
                if (grant_a) begin
                    state_d  = HOLD_A;
                    cnt_d    = LOAD;
                    last_b_d = 1'b0;
                    led_d    = req.REQ_A_DATA;
                    owner_d  = 2'd1;
                end else if (grant_b) begin
                    state_d  = HOLD_B;
                    cnt_d    = LOAD;
                    last_b_d = 1'b1;
                    led_d    = req.REQ_B_DATA;
                    owner_d  = 2'd2;
                end else begin
                    led_d   = SW;
                    owner_d = 2'd0;
                end
            end
            HOLD_A, HOLD_B: begin
                // The exit edge already hands the LEDs back to SW so the
                // pattern is visible for exactly HOLD_CYCLES cycles.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    led_d   = SW;
                    owner_d = 2'd0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                led_d   = SW;
                owner_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_b_q <= 1'b1;
            led_q    <= 8'h00;
            owner_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_b_q <= last_b_d;
            led_q    <= led_d;
            owner_q  <= owner_d;
        end
    end

    assign LED   = led_q;
    assign OWNER = owner_q;
endmodule

// File: tb/tb_led_arbiter.sv
// tb/tb_led_arbiter.sv - randomized and directed self-checking bench for led_arbiter
module tb_led_arbiter;
    logic       CLK;
    logic       rst;
    logic [7:0] sw;
    logic       a_valid, b_valid;
    logic [7:0] a_data, b_data;
    logic [7:0] led0, led1;
    logic [1:0] own0, own1;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;
    bit acc_a  = 0;
    bit acc_b  = 0;

    led_arbiter_if ifa0 ();
    led_arbiter_if ifa1 ();

    assign ifa0.REQ_A_VALID = a_valid;
    assign ifa0.REQ_A_DATA  = a_data;
    assign ifa0.REQ_B_VALID = b_valid;
    assign ifa0.REQ_B_DATA  = b_data;
    assign ifa1.REQ_A_VALID = a_valid;
    assign ifa1.REQ_A_DATA  = a_data;
    assign ifa1.REQ_B_VALID = b_valid;
    assign ifa1.REQ_B_DATA  = b_data;

    led_arbiter #(.HOLD_CYCLES(4)) dut0 (
        .CLK(CLK), .RST(rst), .SW(sw), .req(ifa0.slave), .LED(led0), .OWNER(own0)
    );
    led_arbiter #(.HOLD_CYCLES(1)) dut1 (
        .CLK(CLK), .RST(rst), .SW(sw), .req(ifa1.slave), .LED(led1), .OWNER(own1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: an owner, how many edges of display are left, and who won last.
    int         hold_len [2] = '{4, 1};
    logic [7:0] m_led    [2];
    int         m_own    [2];
    int         m_left   [2];
    bit         m_last_b [2];

    function automatic bit exp_ready_a(int j);
        return !rst && m_left[j] == 0 && a_valid && (!b_valid || m_last_b[j]);
    endfunction

    function automatic bit exp_ready_b(int j);
        return !rst && m_left[j] == 0 && b_valid && (!a_valid || !m_last_b[j]);
    endfunction

    always @(posedge CLK) begin
        for (int j = 0; j < 2; j++) begin
            if (rst) begin
                m_led[j] <= 8'h00; m_own[j] <= 0; m_left[j] <= 0; m_last_b[j] <= 1'b1;
            end else if (m_left[j] > 0) begin
                if (m_left[j] == 1) begin
                    m_led[j] <= sw; m_own[j] <= 0;
                end
                m_left[j] <= m_left[j] - 1;
            end else if (exp_ready_a(j)) begin
                m_led[j] <= a_data; m_own[j] <= 1; m_left[j] <= hold_len[j]; m_last_b[j] <= 1'b0;
            end else if (exp_ready_b(j)) begin
                m_led[j] <= b_data; m_own[j] <= 2; m_left[j] <= hold_len[j]; m_last_b[j] <= 1'b1;
            end else begin
                m_led[j] <= sw; m_own[j] <= 0;
            end
        end
    end

    always @(negedge CLK) begin
        acc_a <= ifa0.REQ_A_READY;
        acc_b <= ifa0.REQ_B_READY;
        if (chk_en) begin
            check("h4_led",     {24'd0, led0}, {24'd0, m_led[0]});
            check("h4_owner",   {30'd0, own0}, m_own[0]);
            check("h4_ready_a", {31'd0, ifa0.REQ_A_READY}, {31'd0, exp_ready_a(0)});
            check("h4_ready_b", {31'd0, ifa0.REQ_B_READY}, {31'd0, exp_ready_b(0)});
            check("h1_led",     {24'd0, led1}, {24'd0, m_led[1]});
            check("h1_owner",   {30'd0, own1}, m_own[1]);
            check("h1_ready_a", {31'd0, ifa1.REQ_A_READY}, {31'd0, exp_ready_a(1)});
            check("h1_ready_b", {31'd0, ifa1.REQ_B_READY}, {31'd0, exp_ready_b(1)});
            check("h4_one_ready", {31'd0, ifa0.REQ_A_READY & ifa0.REQ_B_READY}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [7:0] exp_seq [14];
    int mism;

    initial begin
        rst = 1'b1; sw = 8'h00;
        a_valid = 1'b0; b_valid = 1'b0; a_data = 8'h00; b_data = 8'h00;
        tick(); tick();
        chk_en = 1'b1;

        rst = 1'b0; sw = 8'hA5;
        #1;
        check("rst_ready_a", {31'd0, ifa0.REQ_A_READY}, 32'd0);
        check("rst_ready_b", {31'd0, ifa0.REQ_B_READY}, 32'd0);
        check("rst_led", {24'd0, led0}, 32'h00);
        tick();
        check("sw_led", {24'd0, led0}, 32'hA5);
        check("sw_owner", {30'd0, own0}, 32'd0);

        a_valid = 1'b1; a_data = 8'h3C;
        #1;
        check("a_ready", {31'd0, ifa0.REQ_A_READY}, 32'd1);
        tick();
        a_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("a_hold_led", {24'd0, led0}, 32'h3C);
            check("a_hold_owner", {30'd0, own0}, 32'd1);
            tick();
        end
        check("a_after_led", {24'd0, led0}, 32'hA5);
        check("a_after_owner", {30'd0, own0}, 32'd0);

        do_reset();
        sw = 8'h5A;
        a_valid = 1'b1; a_data = 8'h11; b_valid = 1'b1; b_data = 8'h22;
        exp_seq = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h5A, 8'h22, 8'h22, 8'h22, 8'h22,
                    8'h5A, 8'h11, 8'h11, 8'h11, 8'h11};
        for (int k = 0; k < 14; k++) begin
            #1;
            check("tie_both_ready", {31'd0, ifa0.REQ_A_READY & ifa0.REQ_B_READY}, 32'd0);
            tick();
            check("tie_led", {24'd0, led0}, {24'd0, exp_seq[k]});
        end
        a_valid = 1'b0; b_valid = 1'b0;

        do_reset();
        b_valid = 1'b1; b_data = 8'h77;
        tick();
        b_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("b_hold_led", {24'd0, led0}, 32'h77);
            check("b_hold_owner", {30'd0, own0}, 32'd2);
            sw = ~sw;
            tick();
        end
        check("b_after_led", {24'd0, led0}, {24'd0, sw});

        a_valid = 1'b1; a_data = 8'h3C;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_blocks_ready", {31'd0, ifa0.REQ_A_READY}, 32'd0);
        tick();
        check("abort_led", {24'd0, led0}, 32'h00);
        check("abort_owner", {30'd0, own0}, 32'd0);
        a_valid = 1'b0; rst = 1'b0; sw = 8'h96;
        tick();
        check("release_led", {24'd0, led0}, 32'h96);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (a_valid && acc_a) a_valid = 1'b0;
            if (b_valid && acc_b) b_valid = 1'b0;
            if (!a_valid && $urandom_range(2) == 0) begin a_valid = 1'b1; a_data = 8'($urandom); end
            if (!b_valid && $urandom_range(2) == 0) begin b_valid = 1'b1; b_data = 8'($urandom); end
            if (a_valid && $urandom_range(40) == 0) a_valid = 1'b0;
            sw  = 8'($urandom);
            rst = ($urandom_range(99) == 0);
            tick();
        end

        a_valid = 1'b0; b_valid = 1'b0;
        do_reset();
        mism = 0;
        for (int v = 0; v < 256; v++) begin
            sw = 8'(v);
            for (int r = 0; r < 2; r++) begin
                tick();
                if (led0 !== 8'(v)) mism++;
                check("sweep_led", {24'd0, led0}, v);
            end
        end
        if (mism == 0) $display("sweep PASS");

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
